// File: rtl/debug_info_capture_pkg.sv
// Shared debug-overlay types and sizes, consumed by the capture block and by visuMon.
package visuMon_pkg;

  localparam int DEBUG_DEPTH = 4;
  localparam int DEBUG_CNT_W = 16;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
  } debugEntry;

  typedef struct packed {
    debugEntry [DEBUG_DEPTH-1:0] entry;
    logic [DEBUG_CNT_W-1:0]      accessCount;
    logic [7:0]                  frameCount;
    logic                        bpHit;
  } debugInfo;

  function automatic logic [DEBUG_CNT_W-1:0] sat_inc(input logic [DEBUG_CNT_W-1:0] v);
    return (v == '1) ? v : v + DEBUG_CNT_W'(1);
  endfunction

endpackage

// File: rtl/debug_info_capture_if.sv
// Bus tap from the GM64 core into the debug capture block.
interface debug_info_capture_if;
  logic        i_cs;
  logic        i_busValid;
  logic [15:0] i_addr;
  logic [7:0]  i_data;
  logic        i_rw;

  modport master (output i_cs, i_busValid, i_addr, i_data, i_rw);
  modport slave  (input  i_cs, i_busValid, i_addr, i_data, i_rw);
endinterface

// File: rtl/debug_info_capture_ring_buffer.sv
// Circular store of the most recent bus accesses; readout is ordered newest first.
// DEPTH must be a power of two so the pointer wraps naturally.
module debug_ring_buffer
  import visuMon_pkg::*;
#(
  parameter int DEPTH = DEBUG_DEPTH
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      wr_en_i,
  input  debugEntry wr_entry_i,
  output debugEntry rd_entries_o [DEPTH]
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  debugEntry        ring_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      ring_q[wr_ptr_q] <= wr_entry_i;
      wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
    end
  end

  // Slot wr_ptr-1 holds the newest entry; older ones follow backwards.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_entries_o[i] = ring_q[wr_ptr_q - PTR_W'(i + 1)];
    end
  end

endmodule

// File: rtl/debug_info_capture.sv
// Samples CPU bus accesses and publishes a frame-stable debugInfo snapshot at each vsync fall.
// Optional breakpoint stop is enabled by defining VISUMON_BREAKPOINT_EN.
module debug_info_capture
  import visuMon_pkg::*;
#(
  parameter int DEPTH = DEBUG_DEPTH,
  parameter int CNT_W = DEBUG_CNT_W
) (
  input  logic                 i_clk25Mhz,
  input  logic                 i_reset,
  debug_info_capture_if.slave  bus,
  input  logic                 i_vsync,
  input  logic                 i_freeze,
`ifdef VISUMON_BREAKPOINT_EN
  input  logic [15:0]          i_bpAddr,
  input  logic                 i_bpArm,
  output logic                 o_bpHit,
`endif
  output debugInfo             o_debugInfo,
  output logic                 o_snapshotValid
);

  logic             vsync_q;
  logic             frame_edge;
  logic             bus_acc;
  logic             capture;
  logic             freeze_eff;
  logic             bp_bit;
  logic [CNT_W-1:0] live_cnt_q, live_cnt_d;
  debugInfo         snap_q, snap_d;
  logic             snap_vld_q, snap_vld_d;
  debugEntry        wr_entry;
  debugEntry        ring_view [DEPTH];

  assign frame_edge = vsync_q & ~i_vsync;
  assign bus_acc    = bus.i_busValid & bus.i_cs;

`ifdef VISUMON_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic bp_frz_q, bp_frz_d;

  // The hit stops ring writes at once, but the snapshot freeze only starts
  // after the next frame edge so the trace up to the hit gets published.
  always_comb begin
    bp_hit_d = bp_hit_q;
    bp_frz_d = bp_frz_q;
    if (!i_bpArm) begin
      bp_hit_d = 1'b0;
      bp_frz_d = 1'b0;
    end else begin
      if (bus_acc && !bp_hit_q && (bus.i_addr == i_bpAddr)) begin
        bp_hit_d = 1'b1;
      end
      if (bp_hit_q && frame_edge) begin
        bp_frz_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk25Mhz or posedge i_reset) begin
    if (i_reset) begin
      bp_hit_q <= 1'b0;
      bp_frz_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
      bp_frz_q <= bp_frz_d;
    end
  end

  assign capture    = bus_acc & ~bp_hit_q;
  assign freeze_eff = i_freeze | bp_frz_q;
  assign bp_bit     = bp_hit_q;
  assign o_bpHit    = bp_hit_q;
`else
  assign capture    = bus_acc;
  assign freeze_eff = i_freeze;
  assign bp_bit     = 1'b0;
`endif

  always_comb begin
    wr_entry       = '0;
    wr_entry.valid = 1'b1;
    wr_entry.addr  = bus.i_addr;
    wr_entry.data  = bus.i_data;
    wr_entry.rw    = bus.i_rw;
  end

  debug_ring_buffer #(
    .DEPTH(DEPTH)
  ) u_ring (
    .clk_i       (i_clk25Mhz),
    .rst_i       (i_reset),
    .wr_en_i     (capture),
    .wr_entry_i  (wr_entry),
    .rd_entries_o(ring_view)
  );

  // An access landing on the edge cycle belongs to the new frame.
  always_comb begin
    live_cnt_d = live_cnt_q;
    if (frame_edge) begin
      live_cnt_d = capture ? CNT_W'(1) : '0;
    end else if (capture) begin
      live_cnt_d = sat_inc(live_cnt_q);
    end
  end

  always_comb begin
    snap_d     = snap_q;
    snap_vld_d = snap_vld_q;
    if (frame_edge && !freeze_eff) begin
      for (int i = 0; i < DEPTH; i++) begin
        snap_d.entry[i] = ring_view[i];
      end
      snap_d.accessCount = live_cnt_q;
      snap_d.frameCount  = snap_q.frameCount + 8'd1;
      snap_d.bpHit       = 1'b0;
      snap_vld_d         = 1'b1;
    end
  end

  always_ff @(posedge i_clk25Mhz or posedge i_reset) begin
    if (i_reset) begin
      vsync_q    <= 1'b1;
      live_cnt_q <= '0;
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else begin
      vsync_q    <= i_vsync;
      live_cnt_q <= live_cnt_d;
      snap_q     <= snap_d;
      snap_vld_q <= snap_vld_d;
    end
  end

  always_comb begin
    o_debugInfo       = snap_q;
    o_debugInfo.bpHit = bp_bit;
  end

  assign o_snapshotValid = snap_vld_q;

endmodule

// File: tb/tb_debug_info_capture.sv
// Directed scoreboard bench: expected snapshots are queued as stimulus is issued and popped on each publish.
module tb_debug_info_capture;
  import visuMon_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     vsync;
  logic     freeze;
  debugInfo dbg;
  logic     snap_vld;
`ifdef VISUMON_BREAKPOINT_EN
  logic [15:0] bp_addr;
  logic        bp_arm;
  logic        bp_hit;
`endif

  debug_info_capture_if bus_if ();

  debug_info_capture dut (
    .i_clk25Mhz     (clk),
    .i_reset        (rst),
    .bus            (bus_if.slave),
    .i_vsync        (vsync),
    .i_freeze       (freeze),
`ifdef VISUMON_BREAKPOINT_EN
    .i_bpAddr       (bp_addr),
    .i_bpArm        (bp_arm),
    .o_bpHit        (bp_hit),
`endif
    .o_debugInfo    (dbg),
    .o_snapshotValid(snap_vld)
  );

  always #5 clk = ~clk;

  int       n_pass  = 0;
  int       n_total = 0;
  debugInfo exp_q[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic debugEntry ent(input bit v, input logic [15:0] a, input logic [7:0] d, input bit rw);
    debugEntry e;
    e.valid = v;
    e.addr  = a;
    e.data  = d;
    e.rw    = rw;
    return e;
  endfunction

  function automatic debugInfo strip_bp(input debugInfo x);
    debugInfo y;
    y       = x;
    y.bpHit = 1'b0;
    return y;
  endfunction

  task automatic push_exp(input debugEntry e0, input debugEntry e1, input debugEntry e2,
                          input debugEntry e3, input logic [15:0] cnt, input logic [7:0] fc);
    debugInfo x;
    x             = '0;
    x.entry[0]    = e0;
    x.entry[1]    = e1;
    x.entry[2]    = e2;
    x.entry[3]    = e3;
    x.accessCount = cnt;
    x.frameCount  = fc;
    exp_q.push_back(x);
  endtask

  // Monitor: any change in the published snapshot is a publish event.
  initial begin
    debugInfo prev, cur, e;
    logic     prev_vld;
    prev     = '0;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      cur = strip_bp(dbg);
      if (rst) begin
        prev     = cur;
        prev_vld = snap_vld;
      end else if (cur !== prev || snap_vld !== prev_vld) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_publish: got %h snapshotValid %b", cur, snap_vld);
        end else begin
          e = exp_q.pop_front();
          chk("entries", 160'(cur.entry), 160'(e.entry));
          chk("accessCount", 160'(cur.accessCount), 160'(e.accessCount));
          chk("frameCount", 160'(cur.frameCount), 160'(e.frameCount));
          chk("snapshotValid", 160'(snap_vld), 160'(1'b1));
        end
        prev     = cur;
        prev_vld = snap_vld;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [15:0] a, input logic [7:0] d, input logic rw);
    bus_if.i_busValid = 1'b1;
    bus_if.i_addr     = a;
    bus_if.i_data     = d;
    bus_if.i_rw       = rw;
    tick();
    bus_if.i_busValid = 1'b0;
  endtask

  task automatic vedge_hold(input int n);
    vsync = 1'b0;
    repeat (n) tick();
    vsync = 1'b1;
    tick();
  endtask

  initial begin
    rst               = 1'b1;
    vsync             = 1'b1;
    freeze            = 1'b0;
    bus_if.i_cs       = 1'b1;
    bus_if.i_busValid = 1'b0;
    bus_if.i_addr     = '0;
    bus_if.i_data     = '0;
    bus_if.i_rw       = 1'b0;
`ifdef VISUMON_BREAKPOINT_EN
    bp_addr = 16'h0000;
    bp_arm  = 1'b0;
`endif
    repeat (3) tick();
    chk("reset_debugInfo", 160'(dbg), 160'(0));
    chk("reset_snapshotValid", 160'(snap_vld), 160'(0));
    rst = 1'b0;
    tick();

    // Three reads then a frame edge.
    push_exp(ent(1, 16'hD011, 8'h03, 1), ent(1, 16'hD021, 8'h02, 1),
             ent(1, 16'hD020, 8'h01, 1), ent(0, 16'h0, 8'h0, 0), 16'd3, 8'd1);
    acc(16'hD020, 8'h01, 1);
    acc(16'hD021, 8'h02, 1);
    acc(16'hD011, 8'h03, 1);
    vedge_hold(1);

    // Six writes wrap the 4-entry ring.
    push_exp(ent(1, 16'h0006, 8'h16, 0), ent(1, 16'h0005, 8'h15, 0),
             ent(1, 16'h0004, 8'h14, 0), ent(1, 16'h0003, 8'h13, 0), 16'd6, 8'd2);
    for (int i = 1; i <= 6; i++) acc(16'(i), 8'(8'h10 + i), 0);
    vedge_hold(1);

    // Access coinciding with the edge belongs to the next frame.
    push_exp(ent(1, 16'h0A00, 8'hA0, 1), ent(1, 16'h0006, 8'h16, 0),
             ent(1, 16'h0005, 8'h15, 0), ent(1, 16'h0004, 8'h14, 0), 16'd1, 8'd3);
    acc(16'h0A00, 8'hA0, 1);
    bus_if.i_busValid = 1'b1;
    bus_if.i_addr     = 16'h0B00;
    bus_if.i_data     = 8'hB0;
    bus_if.i_rw       = 1'b0;
    vsync             = 1'b0;
    tick();
    bus_if.i_busValid = 1'b0;
    vsync             = 1'b1;
    tick();
    push_exp(ent(1, 16'h0C00, 8'hC0, 1), ent(1, 16'h0B00, 8'hB0, 0),
             ent(1, 16'h0A00, 8'hA0, 1), ent(1, 16'h0006, 8'h16, 0), 16'd2, 8'd4);
    acc(16'h0C00, 8'hC0, 1);
    vedge_hold(6);

    // Freeze across two edges, then release.
    freeze = 1'b1;
    acc(16'h2000, 8'h20, 0);
    vedge_hold(1);
    acc(16'h2001, 8'h21, 0);
    vedge_hold(1);
    acc(16'h2002, 8'h22, 1);
    freeze = 1'b0;
    push_exp(ent(1, 16'h2002, 8'h22, 1), ent(1, 16'h2001, 8'h21, 0),
             ent(1, 16'h2000, 8'h20, 0), ent(1, 16'h0C00, 8'hC0, 1), 16'd1, 8'd5);
    vedge_hold(1);

    // Chip select low: bus traffic ignored, edges still publish.
    bus_if.i_cs = 1'b0;
    for (int i = 0; i < 10; i++) acc(16'(16'h3000 + i), 8'(i), 0);
    push_exp(ent(1, 16'h2002, 8'h22, 1), ent(1, 16'h2001, 8'h21, 0),
             ent(1, 16'h2000, 8'h20, 0), ent(1, 16'h0C00, 8'hC0, 1), 16'd0, 8'd6);
    vedge_hold(1);
    bus_if.i_cs = 1'b1;

    // 70000 accesses saturate the counter.
    bus_if.i_busValid = 1'b1;
    bus_if.i_rw       = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      bus_if.i_addr = i[15:0];
      bus_if.i_data = i[7:0];
      tick();
    end
    bus_if.i_busValid = 1'b0;
    push_exp(ent(1, 16'h116F, 8'h6F, 0), ent(1, 16'h116E, 8'h6E, 0),
             ent(1, 16'h116D, 8'h6D, 0), ent(1, 16'h116C, 8'h6C, 0), 16'hFFFF, 8'd7);
    vedge_hold(1);

    // Reset mid-frame clears immediately; the next edge publishes normally.
    acc(16'h5000, 8'h50, 1);
    rst = 1'b1;
    #2;
    chk("midreset_debugInfo", 160'(dbg), 160'(0));
    chk("midreset_snapshotValid", 160'(snap_vld), 160'(0));
    tick();
    rst = 1'b0;
    tick();
    push_exp(ent(1, 16'h6000, 8'h60, 0), ent(0, 16'h0, 8'h0, 0),
             ent(0, 16'h0, 8'h0, 0), ent(0, 16'h0, 8'h0, 0), 16'd1, 8'd1);
    acc(16'h6000, 8'h60, 0);
    vedge_hold(1);

`ifdef VISUMON_BREAKPOINT_EN
    bp_addr = 16'hC000;
    bp_arm  = 1'b1;
    acc(16'hC000, 8'hC0, 0);
    chk("bpHit_set", 160'(bp_hit), 160'(1));
    acc(16'h1234, 8'h12, 0);
    push_exp(ent(1, 16'hC000, 8'hC0, 0), ent(1, 16'h6000, 8'h60, 0),
             ent(0, 16'h0, 8'h0, 0), ent(0, 16'h0, 8'h0, 0), 16'd1, 8'd2);
    vedge_hold(1);
    chk("bpHit_mirror", 160'(dbg.bpHit), 160'(1));
    acc(16'h7777, 8'h77, 1);
    vedge_hold(1);
    bp_arm = 1'b0;
    tick();
    chk("bpHit_clear", 160'(bp_hit), 160'(0));
    chk("bpHit_mirror_clear", 160'(dbg.bpHit), 160'(0));
    push_exp(ent(1, 16'h8888, 8'h88, 1), ent(1, 16'hC000, 8'hC0, 0),
             ent(1, 16'h6000, 8'h60, 0), ent(0, 16'h0, 8'h0, 0), 16'd1, 8'd3);
    acc(16'h8888, 8'h88, 1);
    vedge_hold(1);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("pending_publishes", 160'(exp_q.size()), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
